// File: rtl/dot_product_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_arbiter_if
// Description : Requester-side bus of the dot-product arbiter. It carries the
//               per-requester beat streams and the shared response channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface dot_product_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0][7:0][7:0]  req_t_data;
  logic [NUM_REQ-1:0][7:0][7:0]  req_weights;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [31:0]                   rsp_data;
  logic                          rsp_err;

  // Requester side: produces beats, consumes results
  modport master (
    output req_valid, req_last, req_t_data, req_weights, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_last, req_t_data, req_weights, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dot_product_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_arbiter
// Description : Round-robin arbiter sharing one dot-product engine between
//               NUM_REQ requesters. The owner streams beats to the engine,
//               the arbiter waits (bounded by TIMEOUT) for the result and
//               returns it to the owner, flagging truncated or timed-out jobs.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_product_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  dot_product_arbiter_if.slave        bus,
  output logic                        eng_compute,
  output logic [7:0][7:0]             eng_t_data,
  output logic [7:0][7:0]             eng_weights,
  input  logic                        eng_out_valid,
  input  logic [31:0]                 eng_dot_product,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   last_owner;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   rr_idx;
  logic            found;
  logic            err_flag;
  logic [CW-1:0]   drain_cnt;
  logic            own_valid;
  logic            own_last;
  logic            own_rsp_ready;
  logic            timeout_hit;
  logic            any_req;

  assign any_req       = |bus.req_valid;
  assign own_valid     = bus.req_valid[grant_id];
  assign own_last      = bus.req_last[grant_id];
  assign own_rsp_ready = bus.rsp_ready[grant_id];
  // The counter reads TIMEOUT-1 in the TIMEOUT-th drain cycle, so the
  // response state is entered exactly TIMEOUT edges after drain entry.
  assign timeout_hit   = (drain_cnt == CW'(TIMEOUT - 1));
  assign busy          = (state != S_IDLE);
  // Error is only presented alongside a response; elsewhere it stays low.
  assign bus.rsp_err   = (state == S_RESP) && err_flag;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    pick   = '0;
    rr_idx = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_idx = GW'((int'(last_owner) + i) % NUM_REQ);
      if (!found && bus.req_valid[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus the per-requester ready/valid strobes.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    case (state)
      S_IDLE: begin
        if (any_req) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        bus.req_ready[grant_id] = 1'b1;
        // A missing beat ends the burst just like a final beat does.
        if (!own_valid || own_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (eng_out_valid || timeout_hit) state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid[grant_id] = 1'b1;
        if (own_rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Ownership: latch the winner on arbitration, remember it on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id   <= '0;
      last_owner <= GW'(NUM_REQ - 1);
    end else begin
      if (state == S_IDLE && any_req)
        grant_id <= pick;
      if (state == S_RESP && own_rsp_ready)
        last_owner <= grant_id;
    end
  end

  // Engine operand pipeline: one register stage between accept and engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_compute <= 1'b0;
      eng_t_data  <= '0;
      eng_weights <= '0;
    end else begin
      eng_compute <= 1'b0;
      if (state == S_STREAM && own_valid) begin
        eng_compute <= 1'b1;
        eng_t_data  <= bus.req_t_data[grant_id];
        eng_weights <= bus.req_weights[grant_id];
      end
    end
  end

  // Drain timer, result capture and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt    <= '0;
      err_flag     <= 1'b0;
      bus.rsp_data <= '0;
    end else begin
      case (state)
        S_STREAM: begin
          drain_cnt <= '0;
          if (!own_valid) err_flag <= 1'b1;
        end
        S_DRAIN: begin
          if (eng_out_valid) begin
            bus.rsp_data <= eng_dot_product;
          end else if (timeout_hit) begin
            bus.rsp_data <= '0;
            err_flag     <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (own_rsp_ready) err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dot_product_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_product_arbiter
// Description : Randomised bench for dot_product_arbiter with a transaction-
//               level reference model, a behavioural engine and a mid-burst
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_product_arbiter;

  localparam int N   = 4;
  localparam int TO  = 16;
  localparam int GW  = $clog2(N);
  localparam int RUN = 3000;

  localparam int M_IDLE   = 0;
  localparam int M_STREAM = 1;
  localparam int M_DRAIN  = 2;
  localparam int M_RESP   = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            eng_compute;
  logic [7:0][7:0] eng_t_data;
  logic [7:0][7:0] eng_weights;
  logic            eng_out_valid = 1'b0;
  logic [31:0]     eng_dot_product = '0;
  logic            busy;
  logic [GW-1:0]   grant_id;

  dot_product_arbiter_if #(.NUM_REQ(N)) bus ();

  dot_product_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .eng_compute     (eng_compute),
    .eng_t_data      (eng_t_data),
    .eng_weights     (eng_weights),
    .eng_out_valid   (eng_out_valid),
    .eng_dot_product (eng_dot_product),
    .busy            (busy),
    .grant_id        (grant_id)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dot(input logic [63:0] t, input logic [63:0] w);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s += 32'(t[8*i +: 8]) * 32'(w[8*i +: 8]);
    return s;
  endfunction

  function automatic int rr(input int last, input logic [N-1:0] m);
    for (int i = 1; i <= N; i++) begin
      if (m[(last + i) % N]) return (last + i) % N;
    end
    return last;
  endfunction

  // Requester-side burst bookkeeping
  bit          has   [N];
  int          len   [N];
  int          sent  [N];
  int          trunc [N];
  logic [63:0] bt    [N][4];
  logic [63:0] bw    [N][4];

  // Reference model state
  int          ph, own, last_own, drain_edge, resp_at, hold, cyc;
  bit          exp_comp, exp_err;
  logic [63:0] exp_t, exp_w;
  logic [31:0] acc, exp_data;
  logic [N-1:0] vmask;
  bit          result_now;

  task automatic new_burst(input int r, input int force_len);
    has[r]   = 1'b1;
    len[r]   = (force_len > 0) ? force_len : 1 + int'($urandom % 4);
    sent[r]  = 0;
    trunc[r] = (len[r] > 1 && ($urandom % 4) == 0) ? 1 + int'($urandom % (len[r] - 1)) : 0;
    for (int b = 0; b < 4; b++) begin
      bt[r][b] = {$urandom, $urandom};
      bw[r][b] = {$urandom, $urandom};
    end
  endtask

  task automatic model_reset();
    ph = M_IDLE; own = 0; last_own = N - 1; exp_comp = 0; exp_err = 0;
    acc = '0; exp_data = '0; resp_at = -1; hold = 0;
    for (int r = 0; r < N; r++) has[r] = 1'b0;
    bus.req_valid = '0; bus.req_last = '0; bus.rsp_ready = '0;
    bus.req_t_data = '0; bus.req_weights = '0;
    eng_out_valid = 1'b0; eng_dot_product = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_compute"}, eng_compute, 0);
    check({tag, "_t_data"}, eng_t_data, 0);
    check({tag, "_weights"}, eng_weights, 0);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_data"}, bus.rsp_data, 0);
    check({tag, "_rsp_err"}, bus.rsp_err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant_id"}, grant_id, 0);
  endtask

  task automatic enter_drain();
    ph         = M_DRAIN;
    drain_edge = cyc;
    resp_at    = (($urandom % 6) == 0) ? -1 : cyc + 2 + int'($urandom % 4);
  endtask

  bit did_reset = 0;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    for (int r = 0; r < N; r++) new_burst(r, 1);
    cyc = 0;

    for (int k = 0; k < RUN; k++) begin
      @(negedge clk);

      // ---- compare DUT against model state after the last edge ----
      check("busy", busy, 64'(ph != M_IDLE));
      check("req_ready", bus.req_ready, (ph == M_STREAM) ? (64'd1 << own) : 64'd0);
      check("rsp_valid", bus.rsp_valid, (ph == M_RESP) ? (64'd1 << own) : 64'd0);
      check("eng_compute", eng_compute, 64'(exp_comp));
      if (exp_comp) begin
        check("eng_t_data", eng_t_data, exp_t);
        check("eng_weights", eng_weights, exp_w);
      end
      check("grant_id", grant_id, 64'(own));
      if (ph == M_RESP) begin
        check("rsp_data", bus.rsp_data, exp_data);
        check("rsp_err", bus.rsp_err, 64'(exp_err));
      end

      // ---- asynchronous reset in the middle of a burst ----
      if (!did_reset && k > RUN / 2 && ph == M_STREAM) begin
        did_reset = 1;
        rst_n = 1'b0;
        #1;
        check_reset_values("rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < N; r++) new_burst(r, 1);
        cyc++;
        continue;
      end

      // ---- drive requesters ----
      for (int r = 0; r < N; r++) begin
        int bi;
        if (!has[r] && ($urandom % 4) == 0) new_burst(r, 0);
        bi = (sent[r] < 4) ? sent[r] : 0;
        vmask[r] = has[r] && (trunc[r] == 0 || sent[r] < trunc[r]);
        bus.req_valid[r]   = vmask[r];
        bus.req_last[r]    = vmask[r] && (sent[r] == len[r] - 1);
        bus.req_t_data[r]  = bt[r][bi];
        bus.req_weights[r] = bw[r][bi];
      end

      // ---- engine: real result in drain, stray strobes elsewhere ----
      result_now      = (ph == M_DRAIN) && (cyc == resp_at);
      eng_out_valid   = 1'b0;
      eng_dot_product = $urandom;
      if (result_now) begin
        eng_out_valid   = 1'b1;
        eng_dot_product = acc;
      end else if (ph != M_DRAIN && ($urandom % 8) == 0) begin
        eng_out_valid = 1'b1;
      end

      // ---- response acceptance with occasional long backpressure ----
      bus.rsp_ready = N'($urandom);
      if (ph == M_RESP) begin
        if (hold > 0) begin
          bus.rsp_ready[own] = 1'b0;
          hold--;
        end
      end

      // ---- advance the model across the coming edge ----
      exp_comp = 0;
      case (ph)
        M_IDLE: begin
          if (|vmask) begin
            own     = rr(last_own, vmask);
            ph      = M_STREAM;
            exp_err = 0;
            acc     = '0;
          end
        end
        M_STREAM: begin
          if (vmask[own]) begin
            exp_comp = 1;
            exp_t    = bt[own][sent[own]];
            exp_w    = bw[own][sent[own]];
            acc      = acc + dot(exp_t, exp_w);
            sent[own]++;
            if (sent[own] == len[own]) begin
              has[own] = 1'b0;
              enter_drain();
            end
          end else begin
            exp_err  = 1;
            has[own] = 1'b0;
            enter_drain();
          end
        end
        M_DRAIN: begin
          if (result_now) begin
            ph = M_RESP; exp_data = acc; hold = int'($urandom % 12);
          end else if (cyc == drain_edge + TO) begin
            ph = M_RESP; exp_data = '0; exp_err = 1; hold = int'($urandom % 12);
          end
        end
        default: begin
          if (bus.rsp_ready[own]) begin
            last_own = own;
            ph       = M_IDLE;
          end
        end
      endcase
      cyc++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dot_product_arbiter.md
DOT_PRODUCT_ARBITER -- requirements
Module: dot_product_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one dot-product engine (2..8).
REQ-002 Parameter TIMEOUT, default 16, maximum cycles spent waiting for an engine result (>=2).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester beat valid.
REQ-006 req_last  input  NUM_REQ  per-requester final-beat marker.
REQ-007 req_t_data  input  NUM_REQ x 8 x 8  per-requester data vector (8 lanes of 8 bits).
REQ-008 req_weights  input  NUM_REQ x 8 x 8  per-requester weight vector.
REQ-009 req_ready  output  NUM_REQ  beat accepted when req_valid[i] & req_ready[i].
REQ-010 rsp_valid  output  NUM_REQ  result available for requester i.
REQ-011 rsp_ready  input  NUM_REQ  requester i takes the result.
REQ-012 rsp_data  output  32  result value, shared by all requesters.
REQ-013 rsp_err  output  1  result flagged bad (truncated burst or timeout).
REQ-014 eng_compute  output  1  engine compute level; rising edge starts accumulation, falling edge ends it.
REQ-015 eng_t_data / eng_weights  output  8 x 8 each  engine operands.
REQ-016 eng_out_valid  input  1  engine result strobe.
REQ-017 eng_dot_product  input  32  engine result.
REQ-018 busy  output  1  high whenever the state is not IDLE.
REQ-019 grant_id  output  $clog2(NUM_REQ)  index of the current owner; holds its last value while IDLE.

Function
REQ-020 FSM states: IDLE, STREAM, DRAIN, RESP.
REQ-021 IDLE: if any req_valid is high, select the owner round-robin, starting from index last_owner+1 modulo NUM_REQ, register it into grant_id, and go to STREAM on the next edge.
REQ-022 STREAM: req_ready[grant_id]=1 combinationally; all other req_ready bits are 0.
REQ-023 Each accepted beat is registered onto eng_t_data/eng_weights with eng_compute=1 on the next cycle (1-cycle latency).
REQ-024 STREAM exit, normal: an accepted beat with req_last=1 moves the FSM to DRAIN.
REQ-025 STREAM exit, truncation: req_valid[grant_id]=0 in STREAM moves the FSM to DRAIN and sets the sticky error flag.
REQ-026 Back-to-back beats keep eng_compute continuously high; eng_compute=0 in every cycle after the last registered beat.
REQ-027 DRAIN: eng_compute=0 and a counter increments from 0.
REQ-028 DRAIN, result: eng_out_valid=1 captures eng_dot_product into rsp_data and moves the FSM to RESP.
REQ-029 DRAIN, timeout: if the counter reaches TIMEOUT without eng_out_valid, the FSM moves to RESP with rsp_data=0 and the error flag set.
REQ-030 eng_out_valid in any state other than DRAIN is ignored.
REQ-031 RESP: rsp_valid[grant_id]=1 and rsp_err=error flag; rsp_data, rsp_err and grant_id stay stable until rsp_ready[grant_id]=1.
REQ-032 On the RESP handshake: last_owner=grant_id, the error flag clears, and the FSM goes to IDLE.
REQ-033 Request lines of non-owners are ignored while busy; no preemption.
REQ-034 Between any two bursts eng_compute is low for at least 2 cycles (DRAIN + IDLE).
REQ-035 Single-beat burst (valid & last on the first STREAM cycle) is legal and gives exactly 1 cycle of eng_compute=1.
REQ-036 Round-robin wraps: if last_owner=NUM_REQ-1, requester 0 has first priority.

Reset
REQ-037 rst_n low asynchronously forces: state=IDLE, eng_compute=0, eng_t_data=0, eng_weights=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, grant_id=0, last_owner=NUM_REQ-1, error flag=0, counter=0.
REQ-038 Reset mid-burst drops eng_compute immediately; any pending result is discarded and no rsp_valid is issued.
REQ-039 The first arbitration after reset favours requester 0.

Verification
REQ-040 Single owner: req 2 sends 3 beats (last on the 3rd), engine returns 0x0000_1234 two cycles after compute falls -> eng_compute high exactly 3 cycles; rsp_valid[2]=1, rsp_data=0x1234, rsp_err=0.
REQ-041 Fairness: all 4 requesters continuously valid with 1-beat bursts -> grant order 0,1,2,3,0; each rsp_valid is followed by a compute gap of at least 2 cycles.
REQ-042 Timeout: engine never asserts eng_out_valid, TIMEOUT=16 -> RESP entered 16 cycles after DRAIN entry with rsp_data=0 and rsp_err=1.
REQ-043 Truncation: req 1 drops req_valid after 2 beats without req_last -> compute falls; result captured with rsp_err=1; next grant goes to req 2 if it is valid.
REQ-044 Backpressure/reset: rsp_ready held low for 10 cycles -> rsp_valid, rsp_data and grant_id remain stable; an rst_n pulse mid-STREAM -> all outputs return to their reset values in the same cycle.
